// File: rtl/calc_pkg.sv
// Shared calculator types and constants: converter FSM states, BCD digit limit, datapath width.
// Used by dec2bin_conv (optional DEC2BIN_SIGNED_EN build) and the rest of the calculator.
package calc_pkg;

    typedef enum logic [1:0] {IDLE, CONV, FINISH} d2b_state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Common binary operand width so reg_bank, alu and the converters agree.
    localparam int unsigned CALC_BITS = 16;

endpackage

// File: rtl/digit_mac.sv
// One decimal accumulate step: acc*10 + d, at BITS+4 bits so an in-range acc never wraps.
// Also flags a non-BCD digit and a result above 2^BITS-1.
module digit_mac
    import calc_pkg::*;
#(
    parameter int unsigned BITS = CALC_BITS
) (
    input  logic [BITS+3:0] i_acc,
    input  logic [3:0]      i_digit,
    output logic [BITS+3:0] o_acc_next,
    output logic            o_digit_bad,
    output logic            o_ovf_step
);

    localparam logic [BITS+3:0] MaxVal = {4'b0000, {BITS{1'b1}}};

    logic [BITS+3:0] w_sum;

    always_comb begin
        w_sum       = (i_acc << 3) + (i_acc << 1) + {{BITS{1'b0}}, i_digit};
        o_acc_next  = w_sum;
        o_digit_bad = (i_digit > BCD_MAX_DIGIT);
        o_ovf_step  = (w_sum > MaxVal);
    end

endmodule

// File: rtl/dec2bin_conv.sv
// Sequential BCD-to-binary converter, one digit per cycle, MS digit first.
// Define DEC2BIN_SIGNED_EN to add the neg input and two's-complement saturating output.
module dec2bin_conv
    import calc_pkg::*;
#(
    parameter int unsigned BITS   = CALC_BITS,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef DEC2BIN_SIGNED_EN
    input  logic                  neg,
`endif
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BITS-1:0]       bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  invalid
);

    localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Once past 2^BITS the exact value no longer matters, only that it stays too big.
    localparam logic [BITS+3:0] AccClamp = {4'b0001, {BITS{1'b0}}};

    d2b_state_t          r_state;
    logic [4*DIGITS-1:0] r_shift;
    logic [BITS+3:0]     r_acc;
    logic [CntW-1:0]     r_cnt;
    logic                r_ovf;
    logic                r_inv;
    logic [BITS-1:0]     r_bin;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;
    logic                r_invalid;

    logic [BITS+3:0]     w_acc_next;
    logic                w_digit_bad;
    logic                w_ovf_step;
    logic [BITS-1:0]     w_result;
    logic                w_result_ovf;

    digit_mac #(
        .BITS (BITS)
    ) u_digit_mac (
        .i_acc       (r_acc),
        .i_digit     (r_shift[4*DIGITS-1 -: 4]),
        .o_acc_next  (w_acc_next),
        .o_digit_bad (w_digit_bad),
        .o_ovf_step  (w_ovf_step)
    );

`ifdef DEC2BIN_SIGNED_EN
    localparam logic [BITS+3:0] HalfVal = {{(BITS+3){1'b0}}, 1'b1} << (BITS - 1);

    logic r_neg;

    always_comb begin
        w_result_ovf = r_ovf | (r_acc > (r_neg ? HalfVal : HalfVal - 1'b1));
        if (r_inv) begin
            w_result = '0;
        end else if (w_result_ovf) begin
            w_result = r_neg ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
        end else if (r_neg) begin
            w_result = '0 - r_acc[BITS-1:0];
        end else begin
            w_result = r_acc[BITS-1:0];
        end
    end
`else
    always_comb begin
        w_result_ovf = r_ovf;
        if (r_inv) begin
            w_result = '0;
        end else if (r_ovf) begin
            w_result = '1;
        end else begin
            w_result = r_acc[BITS-1:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_inv      <= 1'b0;
            r_bin      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_invalid  <= 1'b0;
`ifdef DEC2BIN_SIGNED_EN
            r_neg      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift <= bcd_in;
                        r_acc   <= '0;
                        r_cnt   <= CntW'(DIGITS - 1);
                        r_ovf   <= 1'b0;
                        r_inv   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= CONV;
`ifdef DEC2BIN_SIGNED_EN
                        r_neg   <= neg;
`endif
                    end
                end
                CONV: begin
                    r_inv   <= r_inv | w_digit_bad;
                    r_ovf   <= r_ovf | w_ovf_step;
                    r_acc   <= w_ovf_step ? AccClamp : w_acc_next;
                    r_shift <= r_shift << 4;
                    if (r_cnt == '0) begin
                        r_state <= FINISH;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FINISH: begin
                    r_bin      <= w_result;
                    r_overflow <= w_result_ovf & ~r_inv;
                    r_invalid  <= r_inv;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bin_out  = r_bin;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign invalid  = r_invalid;

endmodule

// File: tb/tb_dec2bin_conv.sv
// Self-checking bench for dec2bin_conv; reference model works on decimal values directly.
// Covers the DEC2BIN_SIGNED_EN build when that macro is defined.
module tb_dec2bin_conv;

    localparam int unsigned BITS   = 16;
    localparam int unsigned DIGITS = 5;
    localparam int          LAT    = DIGITS + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              neg;
    logic [19:0]       bcd_in;
    logic [BITS-1:0]   bin_out;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              invalid;

    int n_checks = 0;
    int n_fail   = 0;

    dec2bin_conv #(
        .BITS   (BITS),
        .DIGITS (DIGITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef DEC2BIN_SIGNED_EN
        .neg      (neg),
`endif
        .bcd_in   (bcd_in),
        .bin_out  (bin_out),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .invalid  (invalid)
    );

    always #5 clk = ~clk;

    // Decimal value of the digits, then range and saturation rules.
    function automatic void model(input logic [19:0] v, input logic n, output logic [15:0] eb,
                                  output logic eo, output logic ei);
        longint val;
        longint lim;
        val = 0;
        ei  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            int d;
            d = int'(v[4*i +: 4]);
            if (d > 9) ei = 1'b1;
            val = val * 10 + d;
        end
`ifdef DEC2BIN_SIGNED_EN
        lim = n ? 32768 : 32767;
`else
        lim = (n === 1'bz) ? 0 : 65535;
`endif
        if (ei) begin
            eb = '0;
            eo = 1'b0;
        end else if (val > lim) begin
            eo = 1'b1;
`ifdef DEC2BIN_SIGNED_EN
            eb = n ? 16'h8000 : 16'h7FFF;
`else
            eb = 16'hFFFF;
`endif
        end else begin
            eo = 1'b0;
`ifdef DEC2BIN_SIGNED_EN
            eb = n ? 16'(-val) : 16'(val);
`else
            eb = 16'(val);
`endif
        end
    endfunction

    // Call at the negedge right after start was dropped; returns at the negedge done is high.
    task automatic wait_done(output logic [15:0] b, output logic o, output logic iv,
                             output int lat, output int busy_cyc, output bit ok);
        lat      = 1;
        busy_cyc = 0;
        ok       = 1'b0;
        b        = 'x;
        o        = 1'bx;
        iv       = 1'bx;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                b  = bin_out;
                o  = overflow;
                iv = invalid;
                break;
            end
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_conv(input logic [19:0] v, input logic n, output logic [15:0] b,
                            output logic o, output logic iv, output int lat,
                            output int busy_cyc, output bit ok);
        @(negedge clk);
        bcd_in = v;
        neg    = n;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 20'($urandom);
        wait_done(b, o, iv, lat, busy_cyc, ok);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        neg    = 1'b0;
        bcd_in = '0;
        #12;
        n_checks++;
        if (bin_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_bin_out got=%h exp=0000", bin_out);
        end
        n_checks++;
        if ({busy, done, overflow, invalid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, overflow, invalid});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] b; logic o, iv; int lat, bc; bit ok;
        run_conv(20'h12345, 1'b0, b, o, iv, lat, bc, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout no done seen"); end
        n_checks++;
        if (lat != LAT) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
        n_checks++;
        if (bc != DIGITS + 1) begin
            n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, DIGITS + 1);
        end
        n_checks++;
        if ({b, o, iv} !== {16'h3039, 2'b00}) begin
            n_fail++; $display("FAIL basic_result got=%h ovf=%b inv=%b exp=3039 0 0", b, o, iv);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || bin_out !== 16'h3039) begin
            n_fail++; $display("FAIL basic_hold done=%b bin=%h exp done=0 bin=3039", done, bin_out);
        end
    endtask

    task automatic test_boundary();
        logic [19:0] vec [4] = '{20'h65535, 20'h65536, 20'h1A345, 20'h99999};
        logic [15:0] b, eb; logic o, iv, eo, ei; int lat, bc; bit ok;
        foreach (vec[i]) begin
            run_conv(vec[i], 1'b0, b, o, iv, lat, bc, ok);
            model(vec[i], 1'b0, eb, eo, ei);
            n_checks++;
            if (!ok || {b, o, iv} !== {eb, eo, ei}) begin
                n_fail++;
                $display("FAIL boundary_%h ok=%b got=%h/%b/%b exp=%h/%b/%b",
                         vec[i], ok, b, o, iv, eb, eo, ei);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic [15:0] b = 'x;
        @(negedge clk); bcd_in = 20'h00042; neg = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); bcd_in = 20'h00077; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) begin dones++; b = bin_out; end
            @(negedge clk);
        end
        n_checks++;
        if (dones != 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
        n_checks++;
        if (b !== 16'h002A) begin n_fail++; $display("FAIL ignore_result got=%h exp=002a", b); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] b; logic o, iv; int lat, bc; bit ok;
        run_conv(20'h00005, 1'b0, b, o, iv, lat, bc, ok);
        n_checks++;
        if (!ok || b !== 16'h0005) begin
            n_fail++; $display("FAIL b2b_first ok=%b got=%h exp=0005", ok, b);
        end
        bcd_in = 20'h00007;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(b, o, iv, lat, bc, ok);
        n_checks++;
        if (!ok || lat != LAT || b !== 16'h0007) begin
            n_fail++; $display("FAIL b2b_second ok=%b lat=%0d got=%h exp lat=%0d 0007",
                               ok, lat, b, LAT);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        logic [15:0] b; logic o, iv; int lat, bc; bit ok;
        @(negedge clk); bcd_in = 20'h12345; neg = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bin_out, busy, done, overflow, invalid} !== '0) begin
            n_fail++; $display("FAIL midreset_outputs bin=%h flags=%b exp all 0",
                               bin_out, {busy, done, overflow, invalid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones != 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
        run_conv(20'h12345, 1'b0, b, o, iv, lat, bc, ok);
        n_checks++;
        if (!ok || {b, o, iv} !== {16'h3039, 2'b00}) begin
            n_fail++; $display("FAIL midreset_restart ok=%b got=%h/%b/%b exp=3039/0/0", ok, b, o, iv);
        end
    endtask

    task automatic test_signed();
`ifdef DEC2BIN_SIGNED_EN
        logic [19:0] vec [5] = '{20'h00100, 20'h32768, 20'h32769, 20'h00000, 20'h32767};
        logic        nv  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] b, eb; logic o, iv, eo, ei; int lat, bc; bit ok;
        foreach (vec[i]) begin
            run_conv(vec[i], nv[i], b, o, iv, lat, bc, ok);
            model(vec[i], nv[i], eb, eo, ei);
            n_checks++;
            if (!ok || {b, o, iv} !== {eb, eo, ei}) begin
                n_fail++;
                $display("FAIL signed_%h_neg%b ok=%b got=%h/%b/%b exp=%h/%b/%b",
                         vec[i], nv[i], ok, b, o, iv, eb, eo, ei);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [19:0] v; logic n;
        logic [15:0] b, eb; logic o, iv, eo, ei; int lat, bc; bit ok;
        for (int t = 0; t < 40; t++) begin
            v = '0;
            for (int i = 0; i < DIGITS; i++) begin
                v = v << 4;
                v[3:0] = ($urandom_range(0, 15) < 14) ? 4'($urandom_range(0, 9))
                                                      : 4'($urandom_range(10, 15));
            end
            n = 1'($urandom_range(0, 1));
            run_conv(v, n, b, o, iv, lat, bc, ok);
            model(v, n, eb, eo, ei);
            n_checks++;
            if (!ok || lat != LAT || {b, o, iv} !== {eb, eo, ei}) begin
                n_fail++;
                $display("FAIL random_%0d in=%h neg=%b ok=%b lat=%0d got=%h/%b/%b exp=%h/%b/%b",
                         t, v, n, ok, lat, b, o, iv, eb, eo, ei);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_signed();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
